// File: rtl/wishbone_spi_controller.sv
// Wishbone B4 classic slave driving an 8-bit full-duplex SPI master (CPOL/CPHA, divider, soft CS).
// Define SPI_LSB_FIRST_EN to make CTRL[4] (lsb_first) writable; otherwise transfers are always MSB first.
module wishbone_spi_controller #(
  parameter logic [7:0] DIV_RST = 8'd49
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        spi_miso_i,
  output logic        spi_mosi_o,
  output logic        spi_sck_o,
  output logic        spi_cs_o
);

  // Bus: ack rises one cycle after cyc&stb, lasts one cycle; register side effects
  // are applied on the clock edge that ends the ack cycle, while the master still holds the request.
  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, DONE} state_e;

  state_e      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        cpha_q, cpha_d, cpol_q, cpol_d, cs_assert_q, cs_assert_d;
  logic [7:0]  div_q, div_d;
  logic        ctrl_lsb;
  logic        cs_q, sck_q, mosi_q;
  logic [7:0]  sh_q, rx_q, rxdata_q;
  logic        rx_valid_q;
  logic [7:0]  cnt_q;
  logic [4:0]  edge_q;
  logic        xcpha_q, xcpol_q, xlsb_q;
  logic [7:0]  xdiv_q;

  logic        bus_wr, bus_rd, tx_start, half_done, busy;
  logic        load, toggle, leading, shift_out, sample, finish;
  logic        lsb_now, out_bit;
  logic [7:0]  src, src_shift;
  logic [31:0] rd_mux;
  logic        unused_ok;

`ifdef SPI_LSB_FIRST_EN
  logic lsb_q, lsb_d;
  assign ctrl_lsb  = lsb_q;
  assign unused_ok = ^{wb_dat_i[31:16], wb_dat_i[7:5], wb_dat_i[3], wb_sel_i[3:2]};
`else
  assign ctrl_lsb  = 1'b0;
  assign unused_ok = ^{wb_dat_i[31:16], wb_dat_i[7:3], wb_sel_i[3:2]};
`endif

  assign bus_wr    = ack_q & wb_we_i;
  assign bus_rd    = ack_q & ~wb_we_i;
  assign busy      = (state_q != IDLE);
  assign tx_start  = bus_wr & (wb_adr_i == 2'd2) & wb_sel_i[0] & ~busy;
  assign half_done = (cnt_q == 8'd0);

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign spi_cs_o   = cs_q;
  assign spi_sck_o  = sck_q;
  assign spi_mosi_o = mosi_q;

  always_comb begin
    ack_d  = wb_cyc_i & wb_stb_i & ~ack_q;
    rd_mux = 32'd0;
    case (wb_adr_i)
      2'd0: rd_mux = {16'd0, div_q, 3'd0, ctrl_lsb, 1'b0, cs_assert_q, cpol_q, cpha_q};
      2'd1: rd_mux = {30'd0, rx_valid_q, busy};
      2'd3: rd_mux = {24'd0, rxdata_q};
      default: rd_mux = 32'd0;
    endcase
    dat_d = (ack_d & ~wb_we_i) ? rd_mux : 32'd0;
  end

  always_comb begin
    cpha_d      = cpha_q;
    cpol_d      = cpol_q;
    cs_assert_d = cs_assert_q;
    div_d       = div_q;
`ifdef SPI_LSB_FIRST_EN
    lsb_d       = lsb_q;
`endif
    if (bus_wr && wb_adr_i == 2'd0) begin
      if (wb_sel_i[0]) begin
        cpha_d      = wb_dat_i[0];
        cpol_d      = wb_dat_i[1];
        cs_assert_d = wb_dat_i[2];
`ifdef SPI_LSB_FIRST_EN
        lsb_d       = wb_dat_i[4];
`endif
      end
      if (wb_sel_i[1]) div_d = wb_dat_i[15:8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (tx_start) state_d = LEAD;
      LEAD:  if (half_done) state_d = SHIFT;
      SHIFT: if (half_done && edge_q == 5'd15) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // edge_q counts completed SCK edges, so the edge about to happen is odd (leading) when edge_q is even.
  always_comb begin
    load      = (state_q == IDLE) & tx_start;
    toggle    = (state_q == SHIFT) & half_done;
    leading   = ~edge_q[0];
    shift_out = toggle & (xcpha_q ? leading : (~leading & (edge_q != 5'd15)));
    sample    = toggle & (xcpha_q ? ~leading : leading);
    finish    = (state_q == DONE);
    lsb_now   = load ? ctrl_lsb : xlsb_q;
    src       = load ? wb_dat_i[7:0] : sh_q;
    out_bit   = lsb_now ? src[0] : src[7];
    src_shift = lsb_now ? {1'b0, src[7:1]} : {src[6:0], 1'b0};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ack_q       <= 1'b0;
      dat_q       <= 32'd0;
      cpha_q      <= 1'b0;
      cpol_q      <= 1'b0;
      cs_assert_q <= 1'b0;
      div_q       <= DIV_RST;
`ifdef SPI_LSB_FIRST_EN
      lsb_q       <= 1'b0;
`endif
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      sh_q        <= 8'd0;
      rx_q        <= 8'd0;
      rxdata_q    <= 8'd0;
      rx_valid_q  <= 1'b0;
      cnt_q       <= 8'd0;
      edge_q      <= 5'd0;
      xcpha_q     <= 1'b0;
      xcpol_q     <= 1'b0;
      xlsb_q      <= 1'b0;
      xdiv_q      <= 8'd0;
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      cpha_q      <= cpha_d;
      cpol_q      <= cpol_d;
      cs_assert_q <= cs_assert_d;
      div_q       <= div_d;
`ifdef SPI_LSB_FIRST_EN
      lsb_q       <= lsb_d;
`endif
      cs_q        <= ~cs_assert_d;

      if (load) begin
        xcpha_q <= cpha_q;
        xcpol_q <= cpol_q;
        xlsb_q  <= ctrl_lsb;
        xdiv_q  <= div_q;
        cnt_q   <= div_q;
        edge_q  <= 5'd0;
        if (!cpha_q) begin
          mosi_q <= out_bit;
          sh_q   <= src_shift;
        end else begin
          sh_q   <= wb_dat_i[7:0];
        end
      end else if (state_q == LEAD || state_q == SHIFT) begin
        cnt_q <= half_done ? xdiv_q : cnt_q - 8'd1;
      end

      if (toggle) edge_q <= edge_q + 5'd1;
      if (shift_out) begin
        mosi_q <= out_bit;
        sh_q   <= src_shift;
      end
      if (sample) rx_q <= xlsb_q ? {spi_miso_i, rx_q[7:1]} : {rx_q[6:0], spi_miso_i};

      if (state_q == IDLE) sck_q <= cpol_q;
      else if (toggle)     sck_q <= ~sck_q;
      else if (finish)     sck_q <= xcpol_q;

      if (finish) rxdata_q <= rx_q;
      // Completion and an RXDATA read on the same edge leave rx_valid set.
      if (finish)                              rx_valid_q <= 1'b1;
      else if (bus_rd && wb_adr_i == 2'd3)     rx_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wishbone_spi_controller.sv
// Directed bench for wishbone_spi_controller: bus timing, SPI modes 0/3, busy handling, reset, byte selects.
module tb_wishbone_spi_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [1:0]  adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack;
  logic        miso, mosi, sck, cs;
  logic        loop_en, miso_val;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rd;
  logic        ack_ok;
  int          cycles, nrise;
  logic [7:0]  bits;
  logic        bad_half, bad_fall, bad_cs;

  assign miso = loop_en ? mosi : miso_val;

  wishbone_spi_controller #(.DIV_RST(8'd49)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat), .wb_ack_o(ack),
    .spi_miso_i(miso), .spi_mosi_o(mosi), .spi_sck_o(sck), .spi_cs_o(cs)
  );

  always #5 clk = ~clk;

  // One classic access; ack_ok reports "low before, high one cycle after strobe, low after".
  task automatic wb_access(input logic w, input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r, output logic ok);
    logic pre, a1, a2;
    @(negedge clk);
    pre = ack;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    @(negedge clk);
    a1 = ack; r = rdat;
    @(negedge clk);
    a2 = ack;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    ok = (pre === 1'b0) && (a1 === 1'b1) && (a2 === 1'b0);
  endtask

  task automatic watch_xfer(input int n0, input int half, output int cyc_out, output logic [7:0] b,
                            output int nr, output logic bh, output logic bf, output logic bc);
    int n, last;
    logic ps, pm;
    n = n0; last = -1; b = 8'd0; nr = 0; bh = 1'b0; bf = 1'b0; bc = 1'b0;
    ps = sck; pm = mosi;
    while (dut.busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (sck !== ps) begin
        if (last >= 0 && (n - last) != half) bh = 1'b1;
        last = n;
        if (sck === 1'b1) begin
          b = {b[6:0], mosi};
          nr++;
        end
      end
      if (mosi !== pm && !(ps === 1'b1 && sck === 1'b0)) bf = 1'b1;
      if (dut.busy === 1'b1 && cs !== 1'b0) bc = 1'b1;
      ps = sck; pm = mosi;
    end
    cyc_out = n;
  endtask

  task automatic test_reset;
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack got %b exp 0", ack); end
    vectors++; if (rdat !== 32'd0) begin miscompares++; $display("FAIL rst_dat got %h exp 0", rdat); end
    vectors++; if (cs !== 1'b1) begin miscompares++; $display("FAIL rst_cs got %b exp 1", cs); end
    vectors++; if (sck !== 1'b0) begin miscompares++; $display("FAIL rst_sck got %b exp 0", sck); end
    vectors++; if (mosi !== 1'b0) begin miscompares++; $display("FAIL rst_mosi got %b exp 0", mosi); end
    wb_access(1'b0, 2'd0, 32'd0, 4'hF, rd, ack_ok);
    vectors++; if (rd !== 32'h0000_3100) begin miscompares++; $display("FAIL rst_ctrl got %h exp 00003100", rd); end
    vectors++; if (ack_ok !== 1'b1) begin miscompares++; $display("FAIL ack_timing_ctrl got %b exp 1", ack_ok); end
    vectors++; if (rdat !== 32'd0) begin miscompares++; $display("FAIL dat_idle got %h exp 0", rdat); end
    wb_access(1'b0, 2'd1, 32'd0, 4'hF, rd, ack_ok);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL rst_status got %h exp 0", rd); end
    vectors++; if (ack_ok !== 1'b1) begin miscompares++; $display("FAIL ack_timing_status got %b exp 1", ack_ok); end
    wb_access(1'b0, 2'd3, 32'd0, 4'hF, rd, ack_ok);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL rst_rxdata got %h exp 0", rd); end
  endtask

  task automatic test_mode0_loopback;
    loop_en = 1'b1;
    wb_access(1'b1, 2'd0, 32'h0000_0104, 4'hF, rd, ack_ok);
    vectors++; if (ack_ok !== 1'b1) begin miscompares++; $display("FAIL ack_timing_wr got %b exp 1", ack_ok); end
    wb_access(1'b1, 2'd2, 32'h0000_00A5, 4'hF, rd, ack_ok);
    watch_xfer(1, 2, cycles, bits, nrise, bad_half, bad_fall, bad_cs);
    vectors++; if (cycles != 36) begin miscompares++; $display("FAIL m0_busy_cycles got %0d exp 36", cycles); end
    vectors++; if (nrise != 8) begin miscompares++; $display("FAIL m0_rises got %0d exp 8", nrise); end
    vectors++; if (bits !== 8'hA5) begin miscompares++; $display("FAIL m0_mosi_bits got %h exp a5", bits); end
    vectors++; if (bad_half !== 1'b0) begin miscompares++; $display("FAIL m0_half_period got %b exp 0", bad_half); end
    vectors++; if (bad_cs !== 1'b0) begin miscompares++; $display("FAIL m0_cs_low got %b exp 0", bad_cs); end
    wb_access(1'b0, 2'd1, 32'd0, 4'hF, rd, ack_ok);
    vectors++; if (rd !== 32'h2) begin miscompares++; $display("FAIL m0_status got %h exp 2", rd); end
    wb_access(1'b0, 2'd3, 32'd0, 4'hF, rd, ack_ok);
    vectors++; if (rd !== 32'hA5) begin miscompares++; $display("FAIL m0_rxdata got %h exp a5", rd); end
    wb_access(1'b0, 2'd1, 32'd0, 4'hF, rd, ack_ok);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL m0_status2 got %h exp 0", rd); end
  endtask

  task automatic test_mode3;
    loop_en = 1'b0; miso_val = 1'b1;
    wb_access(1'b1, 2'd0, 32'h0000_0107, 4'hF, rd, ack_ok);
    @(negedge clk);
    vectors++; if (sck !== 1'b1) begin miscompares++; $display("FAIL m3_sck_idle got %b exp 1", sck); end
    wb_access(1'b1, 2'd2, 32'h0000_003C, 4'hF, rd, ack_ok);
    watch_xfer(1, 2, cycles, bits, nrise, bad_half, bad_fall, bad_cs);
    vectors++; if (cycles != 36) begin miscompares++; $display("FAIL m3_busy_cycles got %0d exp 36", cycles); end
    vectors++; if (bits !== 8'h3C) begin miscompares++; $display("FAIL m3_mosi_bits got %h exp 3c", bits); end
    vectors++; if (bad_fall !== 1'b0) begin miscompares++; $display("FAIL m3_mosi_on_fall got %b exp 0", bad_fall); end
    vectors++; if (sck !== 1'b1) begin miscompares++; $display("FAIL m3_sck_end got %b exp 1", sck); end
    wb_access(1'b0, 2'd3, 32'd0, 4'hF, rd, ack_ok);
    vectors++; if (rd !== 32'hFF) begin miscompares++; $display("FAIL m3_rxdata got %h exp ff", rd); end
  endtask

  task automatic test_back_to_back;
    loop_en = 1'b1;
    wb_access(1'b1, 2'd0, 32'h0000_0104, 4'hF, rd, ack_ok);
    wb_access(1'b1, 2'd2, 32'h0000_0011, 4'hF, rd, ack_ok);
    wb_access(1'b1, 2'd2, 32'h0000_0022, 4'hF, rd, ack_ok);
    vectors++; if (ack_ok !== 1'b1) begin miscompares++; $display("FAIL b2b_ack got %b exp 1", ack_ok); end
    watch_xfer(4, 2, cycles, bits, nrise, bad_half, bad_fall, bad_cs);
    vectors++; if (cycles != 36) begin miscompares++; $display("FAIL b2b_busy_cycles got %0d exp 36", cycles); end
    vectors++; if (bits !== 8'h11) begin miscompares++; $display("FAIL b2b_mosi_bits got %h exp 11", bits); end
    wb_access(1'b0, 2'd3, 32'd0, 4'hF, rd, ack_ok);
    vectors++; if (rd !== 32'h11) begin miscompares++; $display("FAIL b2b_rxdata got %h exp 11", rd); end
    wb_access(1'b0, 2'd1, 32'd0, 4'hF, rd, ack_ok);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL b2b_status got %h exp 0", rd); end
  endtask

  task automatic test_reset_mid;
    int t, k;
    logic ps;
    loop_en = 1'b1;
    wb_access(1'b1, 2'd2, 32'h0000_005A, 4'hF, rd, ack_ok);
    watch_xfer(1, 2, cycles, bits, nrise, bad_half, bad_fall, bad_cs);
    wb_access(1'b0, 2'd1, 32'd0, 4'hF, rd, ack_ok);
    vectors++; if (rd !== 32'h2) begin miscompares++; $display("FAIL rm_status_pre got %h exp 2", rd); end
    wb_access(1'b1, 2'd2, 32'h0000_00C3, 4'hF, rd, ack_ok);
    t = 0; k = 0; ps = sck;
    while (t < 7 && k < 200) begin
      @(negedge clk);
      k++;
      if (sck !== ps) t++;
      ps = sck;
    end
    vectors++; if (t != 7) begin miscompares++; $display("FAIL rm_reach_edge7 got %0d exp 7", t); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++; if (dut.busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy got %b exp 0", dut.busy); end
    vectors++; if (cs !== 1'b1) begin miscompares++; $display("FAIL rm_cs got %b exp 1", cs); end
    vectors++; if (sck !== 1'b0) begin miscompares++; $display("FAIL rm_sck got %b exp 0", sck); end
    wb_access(1'b0, 2'd1, 32'd0, 4'hF, rd, ack_ok);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rm_status got %h exp 0", rd); end
    wb_access(1'b0, 2'd0, 32'd0, 4'hF, rd, ack_ok);
    vectors++; if (rd !== 32'h0000_3100) begin miscompares++; $display("FAIL rm_ctrl got %h exp 00003100", rd); end
  endtask

  task automatic test_byte_sel;
    wb_access(1'b1, 2'd0, 32'h0000_AA04, 4'b0001, rd, ack_ok);
    wb_access(1'b0, 2'd0, 32'd0, 4'hF, rd, ack_ok);
    vectors++; if (rd !== 32'h0000_3104) begin miscompares++; $display("FAIL sel_ctrl got %h exp 00003104", rd); end
    vectors++; if (cs !== 1'b0) begin miscompares++; $display("FAIL sel_cs got %b exp 0", cs); end
    wb_access(1'b1, 2'd2, 32'h0000_0055, 4'b0010, rd, ack_ok);
    wb_access(1'b0, 2'd1, 32'd0, 4'hF, rd, ack_ok);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL sel_tx_nostart got %h exp 0", rd); end
  endtask

  task automatic test_lsb_first;
    loop_en = 1'b1;
    wb_access(1'b1, 2'd0, 32'h0000_0114, 4'hF, rd, ack_ok);
    wb_access(1'b0, 2'd0, 32'd0, 4'hF, rd, ack_ok);
`ifdef SPI_LSB_FIRST_EN
    vectors++; if (rd !== 32'h0000_0114) begin miscompares++; $display("FAIL lsb_ctrl got %h exp 00000114", rd); end
    wb_access(1'b1, 2'd2, 32'h0000_0001, 4'hF, rd, ack_ok);
    watch_xfer(1, 2, cycles, bits, nrise, bad_half, bad_fall, bad_cs);
    vectors++; if (bits !== 8'h80) begin miscompares++; $display("FAIL lsb_mosi_bits got %h exp 80", bits); end
    wb_access(1'b0, 2'd3, 32'd0, 4'hF, rd, ack_ok);
    vectors++; if (rd !== 32'h01) begin miscompares++; $display("FAIL lsb_rxdata got %h exp 01", rd); end
`else
    vectors++; if (rd !== 32'h0000_0104) begin miscompares++; $display("FAIL lsb_ctrl got %h exp 00000104", rd); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 2'd0; wdat = 32'd0;
    loop_en = 1'b0; miso_val = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_mode0_loopback;
    test_mode3;
    test_back_to_back;
    test_reset_mid;
    test_byte_sel;
    test_lsb_first;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
